// File: rtl/mm_job_sequencer.sv
// Job sequencer for the 2x2 MatrixMulUnit register bus: accepts four operands, writes and
// triggers the unit, waits a fixed compute time, reads four results back and hands them out.
module mm_job_sequencer #(
  parameter int          WIDTH        = 16,
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0040,
  parameter int          WAIT_CYCLES  = 5,
  parameter logic [7:0]  START_CODE   = 8'hFF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [WIDTH-1:0]   job_a0,
  input  logic [WIDTH-1:0]   job_a1,
  input  logic [WIDTH-1:0]   job_b0,
  input  logic [WIDTH-1:0]   job_b1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res0,
  output logic [2*WIDTH-1:0] res1,
  output logic [2*WIDTH-1:0] res2,
  output logic [2*WIDTH-1:0] res3,
  output logic               busy,
  output logic               mm_wen,
  output logic [21:0]        mm_addr,
  output logic [WIDTH-1:0]   mm_wdata,
  input  logic [2*WIDTH-1:0] mm_rdata
);

  localparam logic [21:0] BASE = BASE_ADDRESS[21:0];
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_START,
    S_WAIT,
    S_READ,
    S_RESP
  } state_t;

  state_t             state;
  logic [1:0]         beat;
  logic               rd_capture;
  logic [CW-1:0]      wait_cnt;
  logic [WIDTH-1:0]   ops [4];
  logic [2*WIDTH-1:0] res [4];

  // Register offsets are 4-byte apart; index 4 is the control (trigger) register.
  function automatic logic [21:0] beat_addr(input logic [2:0] idx);
    return BASE + {17'd0, idx, 2'b00};
  endfunction

  assign res0 = res[0];
  assign res1 = res[1];
  assign res2 = res[2];
  assign res3 = res[3];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      beat       <= 2'd0;
      rd_capture <= 1'b0;
      wait_cnt   <= '0;
      job_ready  <= 1'b1;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      mm_wen     <= 1'b0;
      mm_addr    <= BASE;
      mm_wdata   <= '0;
      for (int i = 0; i < 4; i++) begin
        ops[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            ops[0]    <= job_a0;
            ops[1]    <= job_a1;
            ops[2]    <= job_b0;
            ops[3]    <= job_b1;
            state     <= S_WRITE;
            beat      <= 2'd0;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            mm_wen    <= 1'b1;
            mm_addr   <= beat_addr(3'd0);
            mm_wdata  <= job_a0;
          end
        end

        S_WRITE: begin
          if (beat == 2'd3) begin
            state    <= S_START;
            mm_addr  <= beat_addr(3'd4);
            mm_wdata <= WIDTH'(START_CODE);
          end else begin
            beat     <= beat + 2'd1;
            mm_addr  <= beat_addr({1'b0, beat + 2'd1});
            mm_wdata <= ops[beat + 2'd1];
          end
        end

        S_START: begin
          state    <= S_WAIT;
          wait_cnt <= WAIT_LOAD;
          mm_wen   <= 1'b0;
          mm_wdata <= '0;
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            state      <= S_READ;
            beat       <= 2'd0;
            rd_capture <= 1'b0;
            mm_addr    <= beat_addr(3'd0);
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        // Each read beat holds the address two cycles; the unit's data is sampled on the second.
        S_READ: begin
          if (!rd_capture) begin
            rd_capture <= 1'b1;
          end else begin
            rd_capture <= 1'b0;
            res[beat]  <= mm_rdata;
            if (beat == 2'd3) begin
              state     <= S_RESP;
              res_valid <= 1'b1;
            end else begin
              beat    <= beat + 2'd1;
              mm_addr <= beat_addr({1'b0, beat + 2'd1});
            end
          end
        end

        S_RESP: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            mm_addr   <= BASE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Bench for mm_job_sequencer: a stand-in MatrixMulUnit on the register bus plus directed and
// randomized jobs checked against expected write traffic, results and latency.
module tb_mm_job_sequencer;

  localparam int          W    = 16;
  localparam int          WAIT = 5;
  localparam logic [21:0] BASE = 22'h000040;

  logic          clk = 1'b0;
  logic          resetn;
  logic          job_valid;
  logic          job_ready;
  logic [W-1:0]  job_a0, job_a1, job_b0, job_b1;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res0, res1, res2, res3;
  logic          busy;
  logic          mm_wen;
  logic [21:0]   mm_addr;
  logic [W-1:0]  mm_wdata;
  logic [31:0]   mm_rdata = '0;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Unit stand-in state: operand registers, computed results, pass-through table and write log.
  logic [W-1:0]  u_op  [4] = '{default: '0};
  logic [31:0]   u_res [4] = '{default: '0};
  logic [31:0]   pt    [4] = '{default: '0};
  logic          pt_mode = 1'b0;
  logic [37:0]   wr_q [$];

  mm_job_sequencer #(
    .WIDTH(W), .BASE_ADDRESS(32'h1000_0040), .WAIT_CYCLES(WAIT), .START_CODE(8'hFF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a0(job_a0), .job_a1(job_a1), .job_b0(job_b0), .job_b1(job_b1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3),
    .busy(busy),
    .mm_wen(mm_wen), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read unit: data for the presented address appears one cycle later.
  always @(posedge clk) begin
    if (mm_wen) begin
      wr_q.push_back({mm_addr, mm_wdata});
      if (mm_addr >= 22'h40 && mm_addr < 22'h50) u_op[mm_addr[3:2]] <= mm_wdata;
      if (mm_addr == 22'h50 && mm_wdata == 16'h00FF) begin
        u_res[0] <= 32'(u_op[0]) * 32'(u_op[2]) + 32'(u_op[1]) * 32'(u_op[3]);
        u_res[1] <= {u_op[0], u_op[1]};
        u_res[2] <= {u_op[2], u_op[3]};
        u_res[3] <= (32'(u_op[1]) * 32'(u_op[2])) ^ 32'h5A5A_5A5A;
      end
    end
    mm_rdata <= pt_mode ? pt[mm_addr[3:2]] : u_res[mm_addr[3:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one complete job; hold = cycles res_ready stays low in RESP, pulse = busy-time offer.
  task automatic applyStimulus(input logic [W-1:0] a0, input logic [W-1:0] a1,
                               input logic [W-1:0] b0, input logic [W-1:0] b1,
                               input int hold, input bit pulse);
    logic [31:0] exp_res [4];
    logic [37:0] exp_wr  [5];
    logic [31:0] held    [4];
    int n;
    if (pt_mode) begin
      for (int i = 0; i < 4; i++) exp_res[i] = pt[i];
    end else begin
      exp_res[0] = 32'(a0) * 32'(b0) + 32'(a1) * 32'(b1);
      exp_res[1] = {a0, a1};
      exp_res[2] = {b0, b1};
      exp_res[3] = (32'(a1) * 32'(b0)) ^ 32'h5A5A_5A5A;
    end
    exp_wr[0] = {BASE,          a0};
    exp_wr[1] = {BASE + 22'd4,  a1};
    exp_wr[2] = {BASE + 22'd8,  b0};
    exp_wr[3] = {BASE + 22'd12, b1};
    exp_wr[4] = {BASE + 22'd16, 16'h00FF};

    wr_q.delete();
    job_a0 = a0; job_a1 = a1; job_b0 = b0; job_b1 = b1;
    job_valid = 1'b1;
    res_ready = (hold == 0);
    tick();
    job_valid = 1'b0;
    job_a0 = W'($urandom); job_a1 = W'($urandom); job_b0 = W'($urandom); job_b1 = W'($urandom);
    checkOutput("accept_busy", 64'(busy), 64'd1);

    n = 0;
    while (!res_valid && n < 200) begin
      if (pulse && n == 7) begin
        job_a0 = ~a0; job_a1 = ~a1; job_b0 = ~b0; job_b1 = ~b1;
        job_valid = 1'b1;
      end
      if (pulse && n == 9) job_valid = 1'b0;
      checkOutput("busy_job_ready", 64'(job_ready), 64'd0);
      tick();
      n++;
    end
    job_valid = 1'b0;
    checkOutput("latency", 64'(n), 64'(13 + WAIT));

    checkOutput("write_count", 64'(wr_q.size()), 64'd5);
    if (wr_q.size() == 5)
      for (int i = 0; i < 5; i++) checkOutput($sformatf("write%0d", i), 64'(wr_q[i]), 64'(exp_wr[i]));
    checkOutput("res0", 64'(res0), 64'(exp_res[0]));
    checkOutput("res1", 64'(res1), 64'(exp_res[1]));
    checkOutput("res2", 64'(res2), 64'(exp_res[2]));
    checkOutput("res3", 64'(res3), 64'(exp_res[3]));

    held[0] = res0; held[1] = res1; held[2] = res2; held[3] = res3;
    for (int c = 0; c < hold; c++) begin
      tick();
      checkOutput("hold_valid", 64'(res_valid), 64'd1);
      checkOutput("hold_job_ready", 64'(job_ready), 64'd0);
      checkOutput("hold_wen", 64'(mm_wen), 64'd0);
      checkOutput("hold_res", {res0, res1} ^ {res2, res3}, {held[0], held[1]} ^ {held[2], held[3]});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("done_valid", 64'(res_valid), 64'd0);
    checkOutput("done_job_ready", 64'(job_ready), 64'd1);
    checkOutput("done_busy", 64'(busy), 64'd0);
    checkOutput("done_addr", 64'(mm_addr), 64'(BASE));
    checkOutput("retain_res", {res0, res3}, {exp_res[0], exp_res[3]});
    checkOutput("no_extra_writes", 64'(wr_q.size()), 64'd5);
  endtask

  initial begin
    // Reset held while a job is offered.
    resetn = 1'b0; job_valid = 1'b1; res_ready = 1'b0;
    job_a0 = 16'h1111; job_a1 = 16'h2222; job_b0 = 16'h3333; job_b1 = 16'h4444;
    repeat (3) tick();
    checkOutput("rst_job_ready", 64'(job_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_wen", 64'(mm_wen), 64'd0);
    checkOutput("rst_addr", 64'(mm_addr), 64'h40);
    checkOutput("rst_wdata", 64'(mm_wdata), 64'd0);
    checkOutput("rst_res01", {res0, res1}, 64'd0);
    checkOutput("rst_res23", {res2, res3}, 64'd0);
    job_valid = 1'b0;
    resetn = 1'b1;
    tick();

    // Real unit, result consumed on the first RESP edge.
    $display("[TB] job 3,2,1,4 with unit model");
    applyStimulus(16'd3, 16'd2, 16'd1, 16'd4, 0, 1'b0);
    checkOutput("t2_res0_eleven", 64'(res0), 64'd11);

    // Pass-through of raw read data.
    pt_mode = 1'b1;
    pt[0] = 32'hDEAD_BEEF; pt[1] = 32'h0000_0001; pt[2] = 32'h8000_0000; pt[3] = 32'hFFFF_FFFF;
    applyStimulus(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 0, 1'b0);
    pt_mode = 1'b0;

    // Backpressure for 10 cycles.
    applyStimulus(16'd7, 16'd9, 16'd11, 16'd13, 10, 1'b0);

    // Offer during WAIT must be ignored.
    applyStimulus(16'h0102, 16'h0304, 16'h0506, 16'h0708, 0, 1'b1);

    // Reset during WRITE beat 2.
    wr_q.delete();
    job_a0 = 16'd50; job_a1 = 16'd60; job_b0 = 16'd70; job_b1 = 16'd80;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    checkOutput("mid_write_addr", 64'(mm_addr), 64'h48);
    resetn = 1'b0;
    #1;
    checkOutput("async_wen", 64'(mm_wen), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_job_ready", 64'(job_ready), 64'd1);
    checkOutput("async_addr", 64'(mm_addr), 64'h40);
    tick();
    resetn = 1'b1;
    tick();
    tick();
    checkOutput("aborted_writes", 64'(wr_q.size()), 64'd2);
    checkOutput("aborted_idle_wen", 64'(mm_wen), 64'd0);
    applyStimulus(16'd3, 16'd2, 16'd1, 16'd4, 0, 1'b0);
    checkOutput("t6_res0_eleven", 64'(res0), 64'd11);

    // Randomized jobs across both unit modes.
    for (int j = 0; j < 8; j++) begin
      pt_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) pt[i] = $urandom;
      applyStimulus(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
